fifo_umbrales: RTL and testbench



---
 rtl/fifo_umbrales_pkg.sv | 16 +
 rtl/fifo_umbrales_memoria_dp.sv | 48 ++++
 rtl/fifo_umbrales.sv | 109 ++++++++++
 tb/tb_fifo_umbrales.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_umbrales_pkg.sv
// Shared widths and status bundle for the per-lane threshold FIFO.
// Widths here stay in lockstep with the flow-control FSM that reads the flags.
package fifo_umbrales_pkg;

    localparam int FIFO_DATA_WIDTH = 6;
    localparam int FIFO_ADDR_WIDTH = 3;
    localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_umbrales_memoria_dp.sv
// Dual-port storage array with a registered read port.
// rd_data updates only on rd_en and otherwise holds its last word.
module fifo_umbrales_memoria_dp
    import fifo_umbrales_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // The array is deliberately left out of reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_umbrales.sv
// Per-lane FIFO with programmable almost-full/almost-empty thresholds and a
// sticky overflow/underflow flag; read data arrives one cycle after an accepted pop.
module fifo_umbrales
    import fifo_umbrales_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] umbral_alto,
    input  logic [ADDR_WIDTH-1:0] umbral_bajo,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Handshake: push/pop are requests sampled every rising edge; an accepted pop
    // produces data_out with valid_out high for exactly the following cycle,
    // and a rejected request of either kind only raises the sticky error.
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;
    logic                  push_ok;
    logic                  pop_ok;
    fifo_status_t          status;

    always_comb begin
        status.full         = (count_q == CNT_FULL);
        status.empty        = (count_q == '0);
        status.almost_full  = (umbral_alto != '0) && (count_q >= {1'b0, umbral_alto});
        status.almost_empty = (count_q <= {1'b0, umbral_bajo});
    end

    assign pop_ok  = pop & ~status.empty;
    assign push_ok = push & (~status.full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = pop_ok;
        error_d  = error_q | (push & ~push_ok) | (pop & ~pop_ok);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    // Gating with reset keeps a request in the reset cycle from touching the array.
    fifo_umbrales_memoria_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (1 << ADDR_WIDTH)
    ) u_memoria (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok & ~reset),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (pop_ok & ~reset),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );

    assign valid_out    = valid_q;
    assign error        = error_q;
    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;

endmodule

// File: tb/tb_fifo_umbrales.sv
// Directed bench for fifo_umbrales: fill/drain ordering, full pass-through,
// overflow/underflow stickiness, reset mid-burst and live threshold changes.
module tb_fifo_umbrales;
    import fifo_umbrales_pkg::*;

    localparam int DW = FIFO_DATA_WIDTH;
    localparam int AW = FIFO_ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] umbral_alto = 3'd6;
    logic [AW-1:0] umbral_bajo = 3'd1;
    logic          push = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          pop = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          error;

    int pass_cnt = 0;
    int total_cnt = 0;

    fifo_umbrales dut (
        .clk          (clk),
        .reset        (reset),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Drive one cycle of requests, then sample 1 time unit after the edge.
    task automatic cyc(input logic p, input logic q, input logic [DW-1:0] d);
        push = p;
        pop = q;
        data_in = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, '0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        umbral_alto = 3'd6;
        umbral_bajo = 3'd1;
        do_reset();
        cyc(1'b0, 1'b0, '0);
        total_cnt++;
        if ({empty, full, almost_empty, almost_full, valid_out, error} !== 6'b101000) begin
            $display("FAIL reset_flags: got e/f/ae/af/v/err=%b expected 101000",
                     {empty, full, almost_empty, almost_full, valid_out, error});
        end else pass_cnt++;
        total_cnt++;
        if (data_out !== 6'h00) begin
            $display("FAIL reset_data: got %h expected 00", data_out);
        end else pass_cnt++;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, DW'(i));
            total_cnt++;
            if ({full, almost_full, almost_empty, empty} !==
                {(i == 8), (i >= 6), (i <= 1), 1'b0}) begin
                $display("FAIL fill_flags[%0d]: got f/af/ae/e=%b expected %b", i,
                         {full, almost_full, almost_empty, empty},
                         {(i == 8), (i >= 6), (i <= 1), 1'b0});
            end else pass_cnt++;
        end
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 1'b1, '0);
            total_cnt++;
            if (valid_out !== 1'b1 || data_out !== DW'(k)) begin
                $display("FAIL drain_data[%0d]: got v=%b d=%h expected v=1 d=%h",
                         k, valid_out, data_out, DW'(k));
            end else pass_cnt++;
            total_cnt++;
            if ({full, almost_full, almost_empty, empty} !==
                {1'b0, (8 - k >= 6), (8 - k <= 1), (k == 8)}) begin
                $display("FAIL drain_flags[%0d]: got f/af/ae/e=%b expected %b", k,
                         {full, almost_full, almost_empty, empty},
                         {1'b0, (8 - k >= 6), (8 - k <= 1), (k == 8)});
            end else pass_cnt++;
        end
        cyc(1'b0, 1'b0, '0);
        total_cnt++;
        if (valid_out !== 1'b0 || error !== 1'b0 || data_out !== 6'h08) begin
            $display("FAIL drain_idle: got v=%b err=%b d=%h expected v=0 err=0 d=08",
                     valid_out, error, data_out);
        end else pass_cnt++;
    endtask

    task automatic test_full_pushpop();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] exp_w;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, DW'(8'h10 + i));
            exp_q.push_back(DW'(8'h10 + i));
        end
        for (int j = 0; j < 4; j++) begin
            cyc(1'b1, 1'b1, DW'(8'h20 + j));
            exp_q.push_back(DW'(8'h20 + j));
            exp_w = exp_q.pop_front();
            total_cnt++;
            if (valid_out !== 1'b1 || data_out !== exp_w || full !== 1'b1 || error !== 1'b0) begin
                $display("FAIL full_pushpop[%0d]: got v=%b d=%h full=%b err=%b expected v=1 d=%h full=1 err=0",
                         j, valid_out, data_out, full, error, exp_w);
            end else pass_cnt++;
        end
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, '0);
            exp_w = exp_q.pop_front();
            total_cnt++;
            if (valid_out !== 1'b1 || data_out !== exp_w) begin
                $display("FAIL full_drain[%0d]: got v=%b d=%h expected v=1 d=%h",
                         k, valid_out, data_out, exp_w);
            end else pass_cnt++;
        end
        total_cnt++;
        if (empty !== 1'b1 || error !== 1'b0) begin
            $display("FAIL full_end: got e=%b err=%b expected e=1 err=0", empty, error);
        end else pass_cnt++;
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, DW'(8'h30 + i));
        cyc(1'b1, 1'b0, 6'h3f);
        total_cnt++;
        if (full !== 1'b1 || error !== 1'b1 || valid_out !== 1'b0) begin
            $display("FAIL overflow: got full=%b err=%b v=%b expected full=1 err=1 v=0",
                     full, error, valid_out);
        end else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, '0);
            total_cnt++;
            if (valid_out !== 1'b1 || data_out !== DW'(8'h30 + k)) begin
                $display("FAIL overflow_drain[%0d]: got v=%b d=%h expected v=1 d=%h",
                         k, valid_out, data_out, DW'(8'h30 + k));
            end else pass_cnt++;
        end
        cyc(1'b0, 1'b1, '0);
        total_cnt++;
        if (valid_out !== 1'b0 || error !== 1'b1 || empty !== 1'b1 || data_out !== 6'h37) begin
            $display("FAIL underflow: got v=%b err=%b e=%b d=%h expected v=0 err=1 e=1 d=37",
                     valid_out, error, empty, data_out);
        end else pass_cnt++;
        cyc(1'b0, 1'b0, '0);
        total_cnt++;
        if (error !== 1'b1) begin
            $display("FAIL error_sticky: got %b expected 1", error);
        end else pass_cnt++;
    endtask

    task automatic test_pushpop_empty();
        do_reset();
        total_cnt++;
        if (error !== 1'b0 || empty !== 1'b1) begin
            $display("FAIL reset_clears: got err=%b e=%b expected err=0 e=1", error, empty);
        end else pass_cnt++;
        cyc(1'b1, 1'b1, 6'h2a);
        total_cnt++;
        if ({empty, almost_empty, valid_out, error} !== 4'b0101) begin
            $display("FAIL pushpop_empty: got e/ae/v/err=%b expected 0101",
                     {empty, almost_empty, valid_out, error});
        end else pass_cnt++;
        cyc(1'b0, 1'b1, '0);
        total_cnt++;
        if (valid_out !== 1'b1 || data_out !== 6'h2a || empty !== 1'b1) begin
            $display("FAIL pushpop_read: got v=%b d=%h e=%b expected v=1 d=2a e=1",
                     valid_out, data_out, empty);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(8'h01 + i));
        cyc(1'b0, 1'b1, '0);
        cyc(1'b1, 1'b0, 6'h15);
        total_cnt++;
        if (valid_out !== 1'b0 || almost_empty !== 1'b0 || almost_full !== 1'b0 || data_out !== 6'h01) begin
            $display("FAIL mid_before: got v=%b ae=%b af=%b d=%h expected v=0 ae=0 af=0 d=01",
                     valid_out, almost_empty, almost_full, data_out);
        end else pass_cnt++;
        reset = 1'b1;
        cyc(1'b1, 1'b1, 6'h3c);
        reset = 1'b0;
        total_cnt++;
        if ({empty, full, almost_empty, valid_out, error} !== 5'b10100 || data_out !== 6'h00) begin
            $display("FAIL mid_reset: got e/f/ae/v/err=%b d=%h expected 10100 d=00",
                     {empty, full, almost_empty, valid_out, error}, data_out);
        end else pass_cnt++;
        cyc(1'b0, 1'b1, '0);
        total_cnt++;
        if (valid_out !== 1'b0 || error !== 1'b1 || data_out !== 6'h00) begin
            $display("FAIL mid_pop_empty: got v=%b err=%b d=%h expected v=0 err=1 d=00",
                     valid_out, error, data_out);
        end else pass_cnt++;
    endtask

    task automatic test_thresholds();
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, DW'(i));
        total_cnt++;
        if (almost_full !== 1'b1 || almost_empty !== 1'b0 || full !== 1'b0) begin
            $display("FAIL thr_count7: got af=%b ae=%b f=%b expected af=1 ae=0 f=0",
                     almost_full, almost_empty, full);
        end else pass_cnt++;
        umbral_alto = 3'd0;
        #1;
        total_cnt++;
        if (almost_full !== 1'b0) begin
            $display("FAIL thr_alto_zero: got af=%b expected 0", almost_full);
        end else pass_cnt++;
        umbral_alto = 3'd7;
        umbral_bajo = 3'd7;
        #1;
        total_cnt++;
        if (almost_full !== 1'b1 || almost_empty !== 1'b1) begin
            $display("FAIL thr_edge7: got af=%b ae=%b expected af=1 ae=1", almost_full, almost_empty);
        end else pass_cnt++;
        umbral_bajo = 3'd0;
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, '0);
        total_cnt++;
        if (almost_empty !== 1'b1 || empty !== 1'b1 || data_out !== 6'h06) begin
            $display("FAIL thr_bajo_zero: got ae=%b e=%b d=%h expected ae=1 e=1 d=06",
                     almost_empty, empty, data_out);
        end else pass_cnt++;
        umbral_alto = 3'd6;
        umbral_bajo = 3'd1;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_pushpop();
        test_overflow_underflow();
        test_pushpop_empty();
        test_reset_mid();
        test_thresholds();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
